// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity checker.
package serial_parity_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY} sp_state_t;

  localparam logic EVEN_MODE = 1'b0;
  localparam logic ODD_MODE  = 1'b1;

endpackage

// File: rtl/serial_parity_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones, drop to zero on reset or clear
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Bit-serial, frame-based parity checker: WORD_LEN data bits (LSB first)
// followed by one parity bit, then a one-cycle frame_done with the verdict.
// Optional error counter enabled by defining SERIAL_PARITY_ERR_COUNT_EN.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int WORD_LEN = 8,
  parameter int CNT_W    = 8,
  parameter int IDX_W    = $clog2(WORD_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_valid,
  input  logic                bit_in,
  input  logic                odd_mode,
  input  logic                frame_abort,
`ifdef SERIAL_PARITY_ERR_COUNT_EN
  input  logic                clr_cnt,
`endif
  output logic                busy,
  output logic [IDX_W-1:0]    bit_idx,
  output logic                run_parity,
  output logic                frame_done,
  output logic                parity_err,
  output logic [WORD_LEN-1:0] data_out
`ifdef SERIAL_PARITY_ERR_COUNT_EN
  ,
  output logic [CNT_W-1:0]    err_count
`endif
);

  if (WORD_LEN < 1 || CNT_W < 1) begin : g_param_check
    $error("serial_parity_checker: WORD_LEN and CNT_W must be at least 1");
  end

  sp_state_t             state, state_nxt;
  logic [IDX_W-1:0]      idx_nxt;
  logic                  par_nxt;
  logic [WORD_LEN-1:0]   word_q, word_nxt;
  logic                  mode_q, mode_nxt;
  logic                  done_nxt;
  logic                  err_nxt;
  logic [WORD_LEN-1:0]   dout_nxt;
  logic                  total;

  assign busy = (state != IDLE);

  // State register for the frame FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath update; only valid bits advance, abort outside IDLE wins
  always_comb begin
    state_nxt = state;
    idx_nxt   = bit_idx;
    par_nxt   = run_parity;
    word_nxt  = word_q;
    mode_nxt  = mode_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    dout_nxt  = data_out;
    total     = 1'b0;
    if (frame_abort && (state != IDLE)) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      par_nxt   = 1'b0;
    end else if (bit_valid) begin
      case (state)
        IDLE: begin
          mode_nxt    = odd_mode;
          word_nxt[0] = bit_in;
          par_nxt     = bit_in;
          idx_nxt     = IDX_W'(1);
          state_nxt   = (WORD_LEN == 1) ? PARITY : DATA;
        end
        DATA: begin
          for (int i = 0; i < WORD_LEN; i++) begin
            if (bit_idx == IDX_W'(i)) begin
              word_nxt[i] = bit_in;
            end
          end
          par_nxt = run_parity ^ bit_in;
          idx_nxt = bit_idx + 1'b1;
          if (bit_idx == IDX_W'(WORD_LEN - 1)) begin
            state_nxt = PARITY;
          end
        end
        PARITY: begin
          total     = run_parity ^ bit_in;
          err_nxt   = (mode_q == ODD_MODE) ? ~total : total;
          done_nxt  = 1'b1;
          dout_nxt  = word_q;
          state_nxt = IDLE;
          idx_nxt   = '0;
          par_nxt   = 1'b0;
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          par_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers: bit counter, running parity, shift word, latched mode, result
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx    <= '0;
      run_parity <= 1'b0;
      word_q     <= '0;
      mode_q     <= EVEN_MODE;
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      data_out   <= '0;
    end else begin
      bit_idx    <= idx_nxt;
      run_parity <= par_nxt;
      word_q     <= word_nxt;
      mode_q     <= mode_nxt;
      frame_done <= done_nxt;
      parity_err <= err_nxt;
      data_out   <= dout_nxt;
    end
  end

`ifdef SERIAL_PARITY_ERR_COUNT_EN
  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (frame_done && parity_err),
    .count (err_count)
  );
`endif

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Bit-serial, frame-based parity checker; next generation of the single-bit serial parity detector.
- Collects WORD_LEN data bits (LSB first) plus one parity bit, then reports the assembled word and a parity verdict.
- Even/odd mode is selectable per frame; gaps between bits are allowed; a frame can be aborted.
- Sits between a serial line front-end and the word-level consumer.

Parameters:
- WORD_LEN, 8, data bits per frame (>=1).
- CNT_W, 8, width of the error counter (used only with ERR_COUNT_EN).
- IDX_W, $clog2(WORD_LEN+1), width of bit_idx (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial data/parity bit.
- odd_mode  input  1  0=even, 1=odd parity; sampled on the first data bit of a frame.
- frame_abort  input  1  discard the current frame.
- clr_cnt  input  1  clear err_count (used only with ERR_COUNT_EN).
- busy  output  1  frame in progress (state != IDLE).
- bit_idx  output  IDX_W  number of data bits accepted in the current frame.
- run_parity  output  1  XOR of data bits accepted so far.
- frame_done  output  1  one-cycle pulse, frame complete.
- parity_err  output  1  verdict; valid while frame_done=1.
- data_out  output  WORD_LEN  assembled word; valid while frame_done=1, held until the next frame_done.
- err_count  output  CNT_W  saturating error count (only with ERR_COUNT_EN).

Behaviour:
- Decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, busy=0, bit_idx=0, run_parity=0, frame_done=0, parity_err=0, data_out=0, err_count=0.
- Reset mid-frame discards all partial data; no frame_done.
- Only cycles with bit_valid=1 advance the FSM. bit_valid=0 holds all state; gaps are unlimited.
- FSM states: IDLE, DATA, PARITY.
  - IDLE: on a valid bit, latch odd_mode, store the bit at data position 0, set run_parity=bit_in, bit_idx=1. Next state is DATA, or PARITY when WORD_LEN==1.
  - DATA: on a valid bit, store it at position bit_idx, run_parity ^= bit_in, bit_idx++. When bit_idx reaches WORD_LEN, go to PARITY.
  - PARITY: on a valid bit, compute total = run_parity ^ bit_in.
    - parity_err = total in even mode; ~total in odd mode.
    - Next cycle: frame_done=1, parity_err, and data_out updated.
    - FSM returns to IDLE; bit_idx=0, run_parity=0.
- Latency: frame_done asserts exactly 1 cycle after the parity bit is accepted.
- Back-to-back frames: a valid bit in the cycle frame_done is high is the first data bit of the next frame. There are no dead cycles.
- frame_abort=1: next state IDLE, bit_idx=0, run_parity=0, no frame_done. data_out keeps its last completed value.
- frame_abort together with bit_valid: abort wins and the bit is dropped.
- frame_abort in IDLE has no effect.
- odd_mode changes mid-frame are ignored; the latched mode applies for the whole frame.
- parity_err is 0 whenever frame_done is 0.

Optional Feature:
- Macro: SERIAL_PARITY_ERR_COUNT_EN.
- Defined:
  - err_count increments on each frame_done with parity_err=1.
  - Saturates at 2^CNT_W-1.
  - clr_cnt synchronously clears it; clr_cnt wins over a simultaneous increment (result 0).
- Undefined:
  - err_count port and its counter are absent.
  - clr_cnt port is absent.
  - No other behaviour changes.

Decomposition:
- Package serial_parity_pkg contains:
  - typedef enum logic [1:0] {IDLE, DATA, PARITY} sp_state_t;
  - localparam EVEN_MODE=1'b0, ODD_MODE=1'b1.
- One sub-module: sat_counter, a parametrised saturating counter with sync clear. It is instantiated only under the macro.
- The FSM and shift register stay in the top module.

Test Plan:
- WORD_LEN=8, even mode: bits 1,0,1,0,0,1,0,1 (0xA5), then parity 0, with no gaps -> 1 cycle later frame_done=1, data_out=8'hA5, parity_err=0.
- Same word, odd mode, parity 0 -> parity_err=1. With the macro, err_count goes 0->1.
- Even mode, word 0x01 with bit_valid low for 3 cycles between each bit, parity 1 -> frame_done once, data_out=8'h01, parity_err=0. bit_idx holds during gaps.
- Abort after 5 bits, then a full frame 0xFF with parity 0 in even mode -> one frame_done only, data_out=8'hFF, parity_err=0. No pulse at the abort.
- Back-to-back: 0x0F/parity 0, then 0x03/parity 1 with its first bit in the frame_done cycle, even mode -> two pulses 9 cycles apart, parity_err 0 then 1.
- rst pulse after 4 bits, then frame 0x80/parity 1 -> all outputs at reset values the cycle after rst. Next frame_done gives 8'h80, parity_err=0.
- Macro only: CNT_W=2, 4 erroneous frames -> err_count saturates at 3. clr_cnt coincident with a 5th error -> err_count=0.
